// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access / write-back pipeline stage.
//
// Consumes the EX/MEM register outputs. Loads and stores go out over a
// req/ack data-memory bus. While an access is in flight, memStall freezes the
// upstream stages. The MEM/WB register drives the register-file write port
// and the WB forwarding value back to EX.
//
// Ports
//   clk, rst                 rising-edge clock, async active-low reset
//   memAluResIn              ALU result: memory address, or WB data for non-loads
//   memDataIn                store data
//   memRdIn, memRegWriteIn   destination register and its write enable
//   memMemWriteIn            store request
//   memMemReadIn             load request
//   memMemToRegIn            1 = write back load data, 0 = ALU result
//   dmReq, dmWe              memory request and direction (1 = write)
//   dmAddr, dmWdata          address and write data, held stable during a request
//   dmAck, dmRdata           one-cycle completion; read data is valid with the ack
//   memStall                 combinational stall to PC, IF/ID, ID/EX and EX/MEM
//   wbRegWrite, wbRd, wbData MEM/WB register outputs
//   memErr                   sticky access-timeout flag
module mem_wb_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] memAluResIn,
    input  logic [DATA_W-1:0] memDataIn,
    input  logic [REG_AW-1:0] memRdIn,
    input  logic              memRegWriteIn,
    input  logic              memMemWriteIn,
    input  logic              memMemReadIn,
    input  logic              memMemToRegIn,
    output logic              dmReq,
    output logic              dmWe,
    output logic [DATA_W-1:0] dmAddr,
    output logic [DATA_W-1:0] dmWdata,
    input  logic              dmAck,
    input  logic [DATA_W-1:0] dmRdata,
    output logic              memStall,
    output logic              wbRegWrite,
    output logic [REG_AW-1:0] wbRd,
    output logic [DATA_W-1:0] wbData,
    output logic              memErr
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [CNT_W-1:0]  waitCnt;
    logic [CNT_W-1:0]  waitCntNext;
    logic [CNT_W-1:0]  waitCntInc;
    logic [DATA_W-1:0] capData;
    logic [DATA_W-1:0] capDataNext;

    logic              dmReqNext;
    logic              dmWeNext;
    logic [DATA_W-1:0] dmAddrNext;
    logic [DATA_W-1:0] dmWdataNext;
    logic              wbRegWriteNext;
    logic [REG_AW-1:0] wbRdNext;
    logic [DATA_W-1:0] wbDataNext;
    logic              memErrNext;

    logic              access;
    logic              stallRaw;

    assign access     = memMemReadIn | memMemWriteIn;
    assign waitCntInc = waitCnt + CNT_W'(1);

    // Reset overrides the stall so the front end is never held frozen in reset.
    assign memStall = rst & stallRaw;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            waitCnt    <= '0;
            capData    <= '0;
            dmReq      <= 1'b0;
            dmWe       <= 1'b0;
            dmAddr     <= '0;
            dmWdata    <= '0;
            wbRegWrite <= 1'b0;
            wbRd       <= '0;
            wbData     <= '0;
            memErr     <= 1'b0;
        end else begin
            state      <= stateNext;
            waitCnt    <= waitCntNext;
            capData    <= capDataNext;
            dmReq      <= dmReqNext;
            dmWe       <= dmWeNext;
            dmAddr     <= dmAddrNext;
            dmWdata    <= dmWdataNext;
            wbRegWrite <= wbRegWriteNext;
            wbRd       <= wbRdNext;
            wbData     <= wbDataNext;
            memErr     <= memErrNext;
        end
    end

    // Next-state, bus control, stall and MEM/WB update.
    always_comb begin
        stateNext      = state;
        waitCntNext    = waitCnt;
        capDataNext    = capData;
        dmReqNext      = dmReq;
        dmWeNext       = dmWe;
        dmAddrNext     = dmAddr;
        dmWdataNext    = dmWdata;
        wbRegWriteNext = wbRegWrite;
        wbRdNext       = wbRd;
        wbDataNext     = wbData;
        memErrNext     = memErr;
        stallRaw       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (access) begin
                    // Write wins when both load and store are flagged.
                    stallRaw    = 1'b1;
                    dmReqNext   = 1'b1;
                    dmWeNext    = memMemWriteIn;
                    dmAddrNext  = memAluResIn;
                    dmWdataNext = memDataIn;
                    waitCntNext = '0;
                    stateNext   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stallRaw = 1'b1;
                if (dmAck) begin
                    capDataNext = dmWe ? '0 : dmRdata;
                    dmReqNext   = 1'b0;
                    stateNext   = ST_DONE;
                end else if (waitCntInc == CNT_W'(MAX_WAIT)) begin
                    // Timed out: abandon the access and retire with zero data.
                    waitCntNext = waitCntInc;
                    memErrNext  = 1'b1;
                    capDataNext = '0;
                    dmReqNext   = 1'b0;
                    stateNext   = ST_DONE;
                end else begin
                    waitCntNext = waitCntInc;
                end
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
                dmReqNext = 1'b0;
            end
        endcase

        // MEM/WB advances only when the pipeline is not stalled.
        if (!stallRaw) begin
            wbRegWriteNext = memRegWriteIn & (memRdIn != REG_AW'(0));
            wbRdNext       = memRdIn;
            wbDataNext     = memMemToRegIn ? capData : memAluResIn;
        end
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access and write-back stage that consumes the EX/MEM register outputs. It runs load/store accesses over a req/ack data-memory bus and stalls the upstream pipeline until each access completes. It holds the MEM/WB pipeline register and produces the write-back value for the register file and for the WB forwarding path to EX.

Parameters:
DATA_W, 32, data and address width
REG_AW, 5, register index width
MAX_WAIT, 15, WAIT cycles without dmAck before the access is aborted (≥1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
memAluResIn  in  DATA_W  ALU result; used as address and as non-load WB data
memDataIn  in  DATA_W  store data
memRdIn  in  REG_AW  destination register
memRegWriteIn  in  1  register-write control
memMemWriteIn  in  1  store
memMemReadIn  in  1  load
memMemToRegIn  in  1  WB selects load data (1) or ALU result (0)
dmReq  out  1  memory request
dmWe  out  1  1 = write, 0 = read; valid while dmReq is high
dmAddr  out  DATA_W  byte address
dmWdata  out  DATA_W  write data
dmAck  in  1  memory completion, one cycle
dmRdata  in  DATA_W  read data, valid in the dmAck cycle
memStall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
wbRegWrite  out  1  register-file write enable
wbRd  out  REG_AW  write address
wbData  out  DATA_W  write data and WB forwarding value
memErr  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. dmReq, dmWe, dmAddr, dmWdata, wbRegWrite, wbRd, wbData, memErr and the wait counter are all 0. memStall is forced to 0 while rst=0. Reset asserted mid-access drops dmReq at once, and the access is abandoned.
- Access = memMemReadIn | memMemWriteIn. If both are asserted, the write takes priority and the captured load data is 0.
- FSM states and transitions:
  - IDLE, no access: memStall=0.
  - IDLE, access: memStall=1. Latch dmAddr←memAluResIn, dmWdata←memDataIn, dmWe←memMemWriteIn. Clear the counter. Go to WAIT.
  - WAIT: dmReq=1; address, data and dmWe are held stable; memStall=1.
    - dmAck=1: capture dmRdata (0 for a write), drop dmReq next cycle, go to DONE.
    - Else the counter increments. When it reaches MAX_WAIT: set memErr, capture 0, go to DONE. A write is considered lost.
  - DONE: memStall=0, dmReq=0. Always returns to IDLE. A memory access in EX/MEM on the following cycle re-enters the flow.
- Latency: ack on WAIT cycle k (k≥1) gives k+1 stall cycles. The instruction retires into MEM/WB at the end of the DONE cycle.
- MEM/WB register updates only on edges where memStall=0:
  - wbRegWrite←memRegWriteIn & (memRdIn≠0)
  - wbRd←memRdIn
  - wbData←memMemToRegIn ? captured data : memAluResIn
  - On stall cycles the register holds its value, so the WB forwarding value stays valid for the frozen EX stage. Repeated register-file writes of the same value are harmless.
- dmAck outside WAIT, including a late ack after a timeout, is ignored.
- memErr stays set until reset.
- The counter width is ceil(log2(MAX_WAIT+1)).

Test Plan:
1. Reset then ALU op: rst low, then high; aluRes=0x00000010, rd=3, regWrite=1, no mem → all outputs 0 during reset, memStall=0 throughout; next edge wbRegWrite=1, wbRd=3, wbData=0x10.
2. Zero-wait load: read, addr=0x40, memToReg=1, rd=8; memory acks on the first WAIT cycle with 0xDEADBEEF → memStall high 2 cycles; dmReq high 1 cycle with dmAddr=0x40, dmWe=0; after DONE wbData=0xDEADBEEF, wbRd=8.
3. Slow store: write, addr=0x80, data=0x12345678; ack on WAIT cycle 4 → dmWe=1 and dmAddr/dmWdata stable all 4 cycles; memStall high 5 cycles; wbRegWrite=0 after retire.
4. Timeout: read with no ack, MAX_WAIT=15 → dmReq high 15 cycles, then memErr=1 and wbData=0; memStall drops in DONE; a late ack is ignored; memErr stays 1.
5. Back-to-back loads with 2-cycle acks → the second request starts in the IDLE cycle after DONE; wbData updates once per load and is held during the stall.
6. Reset mid-WAIT: rst low on WAIT cycle 2 → dmReq=0 and memStall=0 immediately; after rst releases, the FSM is in IDLE and memErr=0.
